// File: rtl/cam_config_sequencer.sv
// Camera bring-up sequencer: walks a register table into the I2C controller with power-up wait, delay entries and NACK retries.
// Optional CAM_CFG_AUTO_START_EN: run the table once automatically when reset releases.
module cam_config_sequencer #(
  parameter int NUM_REGS     = 64,
  parameter int IDX_W        = 6,
  parameter int PWRUP_CYCLES = 20000,
  parameter int GAP_CYCLES   = 16,
  parameter int DELAY_UNIT   = 1000,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] lut_index,
  input  logic [23:0]      lut_data,
  output logic [23:0]      i2c_data,
  output logic             i2c_enable,
  input  logic             i2c_end,
  input  logic             i2c_ack,
  output logic             busy,
  output logic             config_done,
  output logic             config_error,
  output logic [IDX_W-1:0] err_index
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PWRUP    = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_DECODE   = 4'd3;
  localparam logic [3:0] S_ISSUE    = 4'd4;
  localparam logic [3:0] S_WAIT_END = 4'd5;
  localparam logic [3:0] S_GAP      = 4'd6;
  localparam logic [3:0] S_DELAY    = 4'd7;
  localparam logic [3:0] S_NEXT     = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;
  localparam logic [3:0] S_ERROR    = 4'd10;

  logic [3:0]       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [23:0]      data_q, data_d;
  logic             en_q, en_d;
  logic             ack_q, ack_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] erridx_q, erridx_d;
  logic             start_go;

`ifdef CAM_CFG_AUTO_START_EN
  logic auto_q, auto_d;
  assign auto_d = 1'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) auto_q <= 1'b1;
    else       auto_q <= auto_d;
  end
  assign start_go = start | auto_q;
`else
  assign start_go = start;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    en_d     = en_q;
    ack_d    = ack_q;
    retry_d  = retry_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    erridx_d = erridx_q;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          erridx_d = '0;
          busy_d   = 1'b1;
          cnt_d    = 32'(PWRUP_CYCLES);
          state_d  = S_PWRUP;
        end
      end
      S_PWRUP: begin
        if (cnt_q <= 32'd1) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (lut_data[23:16] == 8'hFF) begin
          if (lut_data[15:0] == 16'd0) begin
            state_d = S_NEXT;
          end else begin
            cnt_d   = 32'(lut_data[15:0]) * 32'(DELAY_UNIT);
            state_d = S_DELAY;
          end
        end else begin
          data_d  = lut_data;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A level-high END left over from idle must not look like completion.
        if (!i2c_end) begin
          en_d    = 1'b1;
          state_d = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (i2c_end) begin
          en_d  = 1'b0;
          ack_d = i2c_ack;
          cnt_d = 32'(GAP_CYCLES);
          if (i2c_ack) begin
            state_d = S_GAP;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_GAP;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
        if (cnt_q <= 32'd1 && !i2c_end) state_d = ack_q ? S_NEXT : S_ISSUE;
      end
      S_DELAY: begin
        if (cnt_q <= 32'd1) state_d = S_NEXT;
        else                cnt_d   = cnt_q - 32'd1;
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d    = 1'b1;
        erridx_d = idx_q;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      retry_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      erridx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      retry_q  <= retry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      erridx_q <= erridx_d;
    end
  end

  assign lut_index    = idx_q;
  assign i2c_data     = data_q;
  assign i2c_enable   = en_q;
  assign busy         = busy_q;
  assign config_done  = done_q;
  assign config_error = err_q;
  assign err_index    = erridx_q;

endmodule
